bin_seq_ctrl: RTL and testbench



---
 rtl/bin_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bin_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_seq_ctrl.sv
// bin_seq_ctrl: sequencer for the binarization datapath.
// Issues a PULSE_LEN-cycle init pulse, waits for init_done, issues a
// PULSE_LEN-cycle binarize pulse, waits for bin_done. Owns the threshold
// register, adjustable only while not busy.
// Optional macro BIN_SEQ_TIMEOUT_EN: bounds each wait state by TIMEOUT cycles
// and enters ERROR when the bound expires.
module bin_seq_ctrl #(
  parameter int unsigned PULSE_LEN  = 10,
  parameter int unsigned THRES_INIT = 10,
  parameter int unsigned THRES_STEP = 1,
  parameter int unsigned TIMEOUT    = 70000,
  parameter int unsigned TO_W       = 17
) (
  input  logic       seq_clk,
  input  logic       seq_rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       thres_up,
  input  logic       thres_dn,
  input  logic       init_done,
  input  logic       bin_done,
  output logic       int_ctrl,
  output logic       bin_ctrl,
  output logic [7:0] thres_length,
  output logic       busy,
  output logic [2:0] seq_state,
  output logic [1:0] status_led
);

  localparam int unsigned PC_W = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT_PULSE = 3'd1,
    S_INIT_WAIT  = 3'd2,
    S_BIN_PULSE  = 3'd3,
    S_BIN_WAIT   = 3'd4,
    S_DONE       = 3'd5,
    S_ERROR      = 3'd6
  } state_e;

  // Reject a timeout counter too narrow to reach TIMEOUT-1.
  if ((TIMEOUT >> TO_W) != 0) begin : g_to_w_chk
    $error("bin_seq_ctrl: TO_W too small for TIMEOUT");
  end

  state_e          state_q, state_d;
  logic [PC_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [7:0]      thres_q, thres_d;
  logic [8:0]      thres_sum, thres_dif;
  logic            idle_like;
  logic            int_ctrl_q, int_ctrl_d;
  logic            bin_ctrl_q, bin_ctrl_d;
  logic            busy_q, busy_d;
  logic [1:0]      led_q, led_d;
`ifdef BIN_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;
`endif

  // Next state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
`ifdef BIN_SEQ_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    to_hit      = (to_cnt_q == TO_W'(TIMEOUT - 1));
`endif
    idle_like   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_INIT_PULSE;
          pulse_cnt_d = '0;
        end
      end
      S_INIT_PULSE: begin
        if (pulse_cnt_q == PC_W'(PULSE_LEN - 1)) begin
          state_d     = S_INIT_WAIT;
          pulse_cnt_d = '0;
`ifdef BIN_SEQ_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else begin
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end
      end
      S_INIT_WAIT: begin
        if (init_done) begin
          state_d = S_BIN_PULSE;
`ifdef BIN_SEQ_TIMEOUT_EN
        end else if (to_hit) begin
          state_d = S_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      S_BIN_PULSE: begin
        if (pulse_cnt_q == PC_W'(PULSE_LEN - 1)) begin
          state_d     = S_BIN_WAIT;
          pulse_cnt_d = '0;
`ifdef BIN_SEQ_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else begin
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end
      end
      S_BIN_WAIT: begin
        if (bin_done) begin
          state_d = S_DONE;
`ifdef BIN_SEQ_TIMEOUT_EN
        end else if (to_hit) begin
          state_d = S_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d     = S_IDLE;
      pulse_cnt_d = '0;
`ifdef BIN_SEQ_TIMEOUT_EN
      to_cnt_d    = '0;
`endif
    end

    // Saturating threshold adjust, only while not running a sequence.
    thres_d   = thres_q;
    thres_sum = {1'b0, thres_q} + 9'(THRES_STEP);
    thres_dif = {1'b0, thres_q} - 9'(THRES_STEP);
    if (idle_like && thres_up && !thres_dn) begin
      thres_d = thres_sum[8] ? 8'hFF : thres_sum[7:0];
    end else if (idle_like && thres_dn && !thres_up) begin
      thres_d = thres_dif[8] ? 8'h00 : thres_dif[7:0];
    end

    // Outputs follow the state being entered so they change on the same edge.
    int_ctrl_d = (state_d == S_INIT_PULSE);
    bin_ctrl_d = (state_d == S_BIN_PULSE);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    case (state_d)
      S_IDLE:  led_d = 2'b00;
      S_DONE:  led_d = 2'b10;
      S_ERROR: led_d = 2'b11;
      default: led_d = 2'b01;
    endcase
  end

  // State, counter, threshold and output registers.
  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state_q     <= S_IDLE;
      pulse_cnt_q <= '0;
      thres_q     <= 8'(THRES_INIT);
      int_ctrl_q  <= 1'b0;
      bin_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
      led_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      thres_q     <= thres_d;
      int_ctrl_q  <= int_ctrl_d;
      bin_ctrl_q  <= bin_ctrl_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

`ifdef BIN_SEQ_TIMEOUT_EN
  // Wait-state timeout counter.
  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign int_ctrl     = int_ctrl_q;
  assign bin_ctrl     = bin_ctrl_q;
  assign thres_length = thres_q;
  assign busy         = busy_q;
  assign seq_state    = state_q;
  assign status_led   = led_q;

endmodule

// File: tb/tb_bin_seq_ctrl.sv
// Self-checking bench for bin_seq_ctrl: scoreboard of expected pulse widths
// plus a threshold model and state/timing checks.
module tb_bin_seq_ctrl;

`ifdef BIN_SEQ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 50;
`else
  localparam int unsigned TB_TIMEOUT = 70000;
`endif

  logic       seq_clk = 1'b0;
  logic       seq_rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, thres_up = 1'b0, thres_dn = 1'b0;
  logic       init_done = 1'b0, bin_done = 1'b0;
  logic       int_ctrl, bin_ctrl, busy;
  logic [7:0] thres_length;
  logic [2:0] seq_state;
  logic [1:0] status_led;

  int n_checks = 0;
  int n_errors = 0;
  int exp_thr  = 10;
  int exp_int_q[$];
  int exp_bin_q[$];
  int int_run = 0, bin_run = 0;
  logic int_prev = 1'b0, bin_prev = 1'b0;

  bin_seq_ctrl #(
    .PULSE_LEN(10), .THRES_INIT(10), .THRES_STEP(1), .TIMEOUT(TB_TIMEOUT), .TO_W(17)
  ) dut (
    .seq_clk(seq_clk), .seq_rst_n(seq_rst_n), .start(start), .abort(abort),
    .thres_up(thres_up), .thres_dn(thres_dn), .init_done(init_done),
    .bin_done(bin_done), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl),
    .thres_length(thres_length), .busy(busy), .seq_state(seq_state),
    .status_led(status_led)
  );

  always #5 seq_clk = ~seq_clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Pulse-width monitor: pops the expected width when a pulse ends.
  always @(negedge seq_clk) begin
    if (!seq_rst_n) begin
      int_run = 0; bin_run = 0; int_prev = 1'b0; bin_prev = 1'b0;
    end else begin
      if (int_ctrl) int_run++;
      else if (int_prev) begin
        if (exp_int_q.size() == 0) chk_val("int_unexpected", 32'(int_run), 32'd0);
        else chk_val("int_width", 32'(int_run), 32'(exp_int_q.pop_front()));
        int_run = 0;
      end
      if (bin_ctrl) bin_run++;
      else if (bin_prev) begin
        if (bin_run == 0 || exp_bin_q.size() == 0) chk_val("bin_unexpected", 32'(bin_run), 32'd0);
        else chk_val("bin_width", 32'(bin_run), 32'(exp_bin_q.pop_front()));
        bin_run = 0;
      end
      int_prev = int_ctrl;
      bin_prev = bin_ctrl;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge seq_clk);
  endtask

  task automatic do_reset();
    seq_rst_n = 1'b0;
    {start, abort, thres_up, thres_dn, init_done, bin_done} = '0;
    repeat (2) tick();
    seq_rst_n = 1'b1;
    exp_thr = 10;
    tick();
  endtask

  // One-cycle adjust pulse; model updated only if the DUT should accept it.
  task automatic pulse_adj(input bit up, input bit dn, input bit applies);
    thres_up = up; thres_dn = dn;
    tick();
    thres_up = 1'b0; thres_dn = 1'b0;
    if (applies && (up != dn)) begin
      if (up) exp_thr = (exp_thr + 1 > 255) ? 255 : exp_thr + 1;
      else    exp_thr = (exp_thr - 1 < 0) ? 0 : exp_thr - 1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (seq_state != s && n < budget) begin
      tick();
      n++;
    end
    chk_val(tag, 32'(seq_state), 32'(s));
  endtask

  initial begin
    // Reset values, then adjust in IDLE.
    do_reset();
    chk_val("rst_state", 32'(seq_state), 32'd0);
    chk_val("rst_int", 32'(int_ctrl), 32'd0);
    chk_val("rst_bin", 32'(bin_ctrl), 32'd0);
    chk_val("rst_thres", 32'(thres_length), 32'd10);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_led", 32'(status_led), 32'd0);
    repeat (5) pulse_adj(1'b1, 1'b0, 1'b1);
    repeat (2) pulse_adj(1'b0, 1'b1, 1'b1);
    chk_val("adj_thres", 32'(thres_length), 32'(exp_thr));
    chk_val("adj_led", 32'(status_led), 32'd0);

    // Full sequence with slow done responses; adjust ignored while busy.
    exp_int_q.push_back(10);
    exp_bin_q.push_back(10);
    pulse_start();
    chk_val("seq_int_rise", 32'(int_ctrl), 32'd1);
    chk_val("seq_state1", 32'(seq_state), 32'd1);
    chk_val("seq_busy", 32'(busy), 32'd1);
    chk_val("seq_led_busy", 32'(status_led), 32'd1);
    repeat (3) pulse_adj(1'b1, 1'b0, 1'b0);
    wait_state(3'd2, 20, "to_init_wait");
    repeat (100) tick();
    chk_val("init_wait_hold", 32'(seq_state), 32'd2);
    init_done = 1'b1;
    wait_state(3'd3, 3, "to_bin_pulse");
    init_done = 1'b0;
    wait_state(3'd4, 20, "to_bin_wait");
    repeat (200) tick();
    chk_val("bin_wait_hold", 32'(seq_state), 32'd4);
    bin_done = 1'b1;
    wait_state(3'd5, 3, "to_done");
    bin_done = 1'b0;
    chk_val("done_led", 32'(status_led), 32'd2);
    chk_val("done_busy", 32'(busy), 32'd0);
    chk_val("busy_adj_ignored", 32'(thres_length), 32'(exp_thr));
    pulse_adj(1'b1, 1'b0, 1'b1);
    chk_val("done_adj", 32'(thres_length), 32'(exp_thr));

    // Saturation at both ends and simultaneous up/dn.
    do_reset();
    repeat (250) pulse_adj(1'b1, 1'b0, 1'b1);
    chk_val("sat_hi", 32'(thres_length), 32'd255);
    repeat (300) pulse_adj(1'b0, 1'b1, 1'b1);
    chk_val("sat_lo", 32'(thres_length), 32'd0);
    pulse_adj(1'b1, 1'b0, 1'b1);
    pulse_adj(1'b1, 1'b1, 1'b1);
    chk_val("up_dn_same", 32'(thres_length), 32'd1);

    // Abort in the 4th BIN_PULSE cycle, with a start in the same cycle.
    do_reset();
    init_done = 1'b1;
    exp_int_q.push_back(10);
    exp_bin_q.push_back(4);
    pulse_start();
    wait_state(3'd3, 20, "abort_to_bin");
    repeat (3) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk_val("abort_bin", 32'(bin_ctrl), 32'd0);
    chk_val("abort_state", 32'(seq_state), 32'd0);
    repeat (3) tick();
    chk_val("abort_start_ign", 32'(seq_state), 32'd0);

    // Done inputs already high: each WAIT lasts one cycle; adjust with start.
    bin_done = 1'b1;
    exp_int_q.push_back(10);
    exp_bin_q.push_back(10);
    thres_up = 1'b1;
    pulse_start();
    thres_up = 1'b0;
    exp_thr = exp_thr + 1;
    chk_val("start_adj_thres", 32'(thres_length), 32'(exp_thr));
    chk_val("start_adj_int", 32'(int_ctrl), 32'd1);
    repeat (10) tick();
    chk_val("fast_init_wait", 32'(seq_state), 32'd2);
    chk_val("fast_int_low", 32'(int_ctrl), 32'd0);
    tick();
    chk_val("fast_bin_rise", 32'(bin_ctrl), 32'd1);
    chk_val("fast_state3", 32'(seq_state), 32'd3);
    repeat (10) tick();
    chk_val("fast_bin_wait", 32'(seq_state), 32'd4);
    tick();
    chk_val("fast_done", 32'(seq_state), 32'd5);

    // Reset mid-sequence drops pulses asynchronously and restores threshold.
    pulse_start();
    repeat (2) tick();
    chk_val("pre_rst_int", 32'(int_ctrl), 32'd1);
    seq_rst_n = 1'b0;
    #1;
    chk_val("async_rst_int", 32'(int_ctrl), 32'd0);
    chk_val("async_rst_thres", 32'(thres_length), 32'd10);
    chk_val("async_rst_state", 32'(seq_state), 32'd0);
    do_reset();

`ifdef BIN_SEQ_TIMEOUT_EN
    // Timeout: init_done held low -> ERROR 50 cycles after entering INIT_WAIT.
    exp_int_q.push_back(10);
    pulse_start();
    repeat (10) tick();
    chk_val("to_enter_wait", 32'(seq_state), 32'd2);
    repeat (49) tick();
    chk_val("to_not_yet", 32'(seq_state), 32'd2);
    tick();
    chk_val("to_error", 32'(seq_state), 32'd6);
    chk_val("to_led", 32'(status_led), 32'd3);
    chk_val("to_busy", 32'(busy), 32'd0);
    exp_int_q.push_back(1);
    pulse_start();
    chk_val("to_restart", 32'(seq_state), 32'd1);
    chk_val("to_restart_int", 32'(int_ctrl), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
`endif

    repeat (2) tick();
    chk_val("sb_int_drain", 32'(exp_int_q.size()), 32'd0);
    chk_val("sb_bin_drain", 32'(exp_bin_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
